reorder_buffer: RTL and testbench

// In-order commit stage of the Tomasulo core and the sole driver of the architectural regfile write port.

---
 rtl/reorder_buffer_pkg.sv | 18 +
 rtl/reorder_buffer.sv | 143 ++++++++++++++
 tb/tb_reorder_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths and the entry record for the reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned ROB_TAG_W = 3;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned DATA_W    = 32;

    // One in-flight instruction awaiting in-order retirement.
    typedef struct packed {
        logic              valid;
        logic              ready;
        logic              has_rd;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit stage: allocates entries at issue, captures CDB results,
// retires the head into the regfile and answers rename lookups by tag.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH,
    parameter int unsigned TAG_W = ROB_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  logic               alloc_has_rd,
    input  logic [4:0]         alloc_rd,
    output logic [TAG_W-1:0]   alloc_tag,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [31:0]        cdb_data,
    input  logic [TAG_W-1:0]   q1_tag,
    input  logic [TAG_W-1:0]   q2_tag,
    output logic               q1_ready,
    output logic               q2_ready,
    output logic [31:0]        q1_data,
    output logic [31:0]        q2_data,
    output logic               commit_we,
    output logic [4:0]         commit_waddr,
    output logic [31:0]        commit_wdata,
    output logic               commit_valid,
    output logic [TAG_W-1:0]   commit_tag,
    output logic               empty,
    output logic [TAG_W:0]     count
);

    localparam int unsigned CNT_W = TAG_W + 1;

    rob_entry_t        entries [DEPTH];
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              alloc_fire;
    logic              commit_fire;
    rob_entry_t        head_entry;
    rob_entry_t        q1_entry;
    rob_entry_t        q2_entry;
    logic              q1_hit;
    logic              q2_hit;

    // Occupancy status; space is judged on the registered count alone.
    always_comb begin
        alloc_ready = (count_q < CNT_W'(DEPTH));
        empty       = (count_q == '0);
        count       = count_q;
        alloc_tag   = tail;
        alloc_fire  = alloc_valid & alloc_ready;
    end

    // Head retirement; suppressed by flush and by reset so squashed work never writes.
    always_comb begin
        head_entry   = entries[head];
        commit_fire  = head_entry.valid & head_entry.ready & ~flush & ~rst;
        commit_valid = commit_fire;
        commit_we    = commit_fire & head_entry.has_rd;
        commit_waddr = '0;
        commit_wdata = '0;
        commit_tag   = '0;
        if (commit_fire) begin
            commit_waddr = head_entry.rd;
            commit_wdata = head_entry.value;
            commit_tag   = head;
        end
    end

    // Operand lookups, bypassing a same-cycle CDB broadcast to a live entry.
    always_comb begin
        q1_entry = entries[q1_tag];
        q2_entry = entries[q2_tag];
        q1_hit   = cdb_valid & (cdb_tag == q1_tag) & q1_entry.valid;
        q2_hit   = cdb_valid & (cdb_tag == q2_tag) & q2_entry.valid;
        q1_ready = q1_entry.ready | q1_hit;
        q2_ready = q2_entry.ready | q2_hit;
        q1_data  = '0;
        q2_data  = '0;
        if (q1_hit) begin
            q1_data = cdb_data;
        end else if (q1_entry.ready) begin
            q1_data = q1_entry.value;
        end
        if (q2_hit) begin
            q2_data = cdb_data;
        end else if (q2_entry.ready) begin
            q2_data = q2_entry.value;
        end
    end

    // Entry storage: reset/flush squash, CDB capture, retirement and allocation.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i].valid <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            if (cdb_valid && entries[cdb_tag].valid) begin
                entries[cdb_tag].ready <= 1'b1;
                entries[cdb_tag].value <= cdb_data;
            end
            if (commit_fire) begin
                entries[head].valid <= 1'b0;
            end
            // Tail is never live while space remains, so this cannot collide with the above.
            if (alloc_fire) begin
                entries[tail].valid  <= 1'b1;
                entries[tail].ready  <= 1'b0;
                entries[tail].has_rd <= alloc_has_rd;
                entries[tail].rd     <= alloc_rd;
                entries[tail].value  <= '0;
            end
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + TAG_W'(1);
            end
            if (commit_fire) begin
                head <= head + TAG_W'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic        alloc_has_rd;
    logic [4:0]  alloc_rd;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [2:0]  q1_tag;
    logic [2:0]  q2_tag;
    logic        q1_ready;
    logic        q2_ready;
    logic [31:0] q1_data;
    logic [31:0] q2_data;
    logic        commit_we;
    logic [4:0]  commit_waddr;
    logic [31:0] commit_wdata;
    logic        commit_valid;
    logic [2:0]  commit_tag;
    logic        empty;
    logic [3:0]  count;

    int checks;
    int failures;

    reorder_buffer #(.DEPTH(8), .TAG_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .q1_tag(q1_tag), .q2_tag(q2_tag),
        .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_data(q1_data), .q2_data(q2_data),
        .commit_we(commit_we), .commit_waddr(commit_waddr),
        .commit_wdata(commit_wdata), .commit_valid(commit_valid),
        .commit_tag(commit_tag), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_has_rd = 1'b0;
        alloc_rd     = '0;
        cdb_valid    = 1'b0;
        cdb_tag      = '0;
        cdb_data     = '0;
        q1_tag       = '0;
        q2_tag       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc_one(input logic has_rd, input logic [4:0] rd);
        alloc_valid  = 1'b1;
        alloc_has_rd = has_rd;
        alloc_rd     = rd;
        tick();
        alloc_valid  = 1'b0;
        alloc_has_rd = 1'b0;
        alloc_rd     = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (alloc_ready !== 1'b1 || empty !== 1'b1 || count !== 4'd0 || alloc_tag !== 3'd0) begin
            failures++;
            $display("FAIL reset_status: ready=%b empty=%b count=%0d tag=%0d, want 1 1 0 0",
                     alloc_ready, empty, count, alloc_tag);
        end
        checks++;
        if (commit_we !== 1'b0 || commit_valid !== 1'b0 || commit_waddr !== 5'd0 ||
            commit_wdata !== 32'd0 || commit_tag !== 3'd0) begin
            failures++;
            $display("FAIL reset_commit: we=%b valid=%b waddr=%0d wdata=%h tag=%0d, want all 0",
                     commit_we, commit_valid, commit_waddr, commit_wdata, commit_tag);
        end
    endtask

    task automatic test_fill_and_full_commit();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (alloc_tag !== 3'(i) || alloc_ready !== 1'b1) begin
                failures++;
                $display("FAIL fill_tag: tag=%0d ready=%b, want %0d 1", alloc_tag, alloc_ready, i);
            end
            alloc_one(1'b1, 5'(i + 1));
        end
        checks++;
        if (count !== 4'd8 || alloc_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_status: count=%0d ready=%b, want 8 0", count, alloc_ready);
        end
        alloc_one(1'b1, 5'd9);
        checks++;
        if (count !== 4'd8 || alloc_tag !== 3'd0) begin
            failures++;
            $display("FAIL ninth_refused: count=%0d tag=%0d, want 8 0", count, alloc_tag);
        end
        // make head ready, then commit while full with alloc requested
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h0000_00AA;
        tick();
        cdb_valid = 1'b0;
        alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd20;
        #1;
        checks++;
        if (commit_valid !== 1'b1 || commit_tag !== 3'd0 || alloc_ready !== 1'b0 ||
            commit_wdata !== 32'h0000_00AA || commit_waddr !== 5'd1) begin
            failures++;
            $display("FAIL full_commit: valid=%b tag=%0d ready=%b wdata=%h waddr=%0d, want 1 0 0 000000aa 1",
                     commit_valid, commit_tag, alloc_ready, commit_wdata, commit_waddr);
        end
        tick();
        checks++;
        if (count !== 4'd7 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin
            failures++;
            $display("FAIL full_after_commit: count=%0d ready=%b tag=%0d, want 7 1 0",
                     count, alloc_ready, alloc_tag);
        end
        tick();
        alloc_valid = 1'b0;
        #1;
        checks++;
        if (count !== 4'd8 || alloc_tag !== 3'd1) begin
            failures++;
            $display("FAIL wrap_alloc: count=%0d tag=%0d, want 8 1", count, alloc_tag);
        end
    endtask

    task automatic test_single_commit();
        do_reset();
        alloc_one(1'b1, 5'd5);
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h0000_1234;
        #1;
        checks++;
        if (commit_valid !== 1'b0 || commit_we !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass_commit: valid=%b we=%b, want 0 0", commit_valid, commit_we);
        end
        tick();
        cdb_valid = 1'b0;
        #1;
        checks++;
        if (commit_we !== 1'b1 || commit_waddr !== 5'd5 || commit_wdata !== 32'h0000_1234 ||
            commit_tag !== 3'd0 || commit_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_commit: we=%b waddr=%0d wdata=%h tag=%0d valid=%b, want 1 5 00001234 0 1",
                     commit_we, commit_waddr, commit_wdata, commit_tag, commit_valid);
        end
        tick();
        checks++;
        if (empty !== 1'b1 || count !== 4'd0 || commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_empty: empty=%b count=%0d valid=%b, want 1 0 0", empty, count, commit_valid);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        alloc_one(1'b1, 5'd1);
        alloc_one(1'b1, 5'd2);
        alloc_one(1'b0, 5'd7);
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'h0000_0011;
        tick();
        cdb_tag = 3'd2; cdb_data = 32'h0000_0033;
        #1;
        checks++;
        if (commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL ooo_head_wait: valid=%b, want 0", commit_valid);
        end
        tick();
        cdb_tag = 3'd0; cdb_data = 32'h0000_0022;
        tick();
        cdb_valid = 1'b0;
        #1;
        checks++;
        if (commit_valid !== 1'b1 || commit_tag !== 3'd0 || commit_waddr !== 5'd1 ||
            commit_wdata !== 32'h0000_0022) begin
            failures++;
            $display("FAIL ooo_first: valid=%b tag=%0d waddr=%0d wdata=%h, want 1 0 1 00000022",
                     commit_valid, commit_tag, commit_waddr, commit_wdata);
        end
        tick();
        checks++;
        if (commit_valid !== 1'b1 || commit_tag !== 3'd1 || commit_waddr !== 5'd2 ||
            commit_wdata !== 32'h0000_0011 || count !== 4'd2) begin
            failures++;
            $display("FAIL ooo_second: valid=%b tag=%0d waddr=%0d wdata=%h count=%0d, want 1 1 2 00000011 2",
                     commit_valid, commit_tag, commit_waddr, commit_wdata, count);
        end
        tick();
        checks++;
        if (commit_valid !== 1'b1 || commit_we !== 1'b0 || commit_tag !== 3'd2 ||
            commit_wdata !== 32'h0000_0033) begin
            failures++;
            $display("FAIL no_rd_commit: valid=%b we=%b tag=%0d wdata=%h, want 1 0 2 00000033",
                     commit_valid, commit_we, commit_tag, commit_wdata);
        end
        tick();
        checks++;
        if (empty !== 1'b1 || commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL ooo_empty: empty=%b valid=%b, want 1 0", empty, commit_valid);
        end
    endtask

    task automatic test_lookup();
        do_reset();
        alloc_one(1'b1, 5'd3);
        alloc_one(1'b1, 5'd4);
        alloc_one(1'b1, 5'd6);
        q1_tag = 3'd2; q2_tag = 3'd1;
        #1;
        checks++;
        if (q1_ready !== 1'b0 || q1_data !== 32'd0 || q2_ready !== 1'b0 || q2_data !== 32'd0) begin
            failures++;
            $display("FAIL lookup_not_ready: q1=%b/%h q2=%b/%h, want 0/0 0/0",
                     q1_ready, q1_data, q2_ready, q2_data);
        end
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'h0000_BEEF;
        #1;
        checks++;
        if (q1_ready !== 1'b1 || q1_data !== 32'h0000_BEEF || q2_ready !== 1'b0 || q2_data !== 32'd0) begin
            failures++;
            $display("FAIL lookup_bypass: q1=%b/%h q2=%b/%h, want 1/0000beef 0/0",
                     q1_ready, q1_data, q2_ready, q2_data);
        end
        tick();
        cdb_tag = 3'd5; cdb_data = 32'h0000_5555;
        q2_tag = 3'd5;
        #1;
        checks++;
        if (q1_ready !== 1'b1 || q1_data !== 32'h0000_BEEF || q2_ready !== 1'b0 || q2_data !== 32'd0) begin
            failures++;
            $display("FAIL lookup_stored: q1=%b/%h q2(invalid tag)=%b/%h, want 1/0000beef 0/0",
                     q1_ready, q1_data, q2_ready, q2_data);
        end
        tick();
        cdb_valid = 1'b0;
        #1;
        checks++;
        if (q2_ready !== 1'b0 || count !== 4'd3) begin
            failures++;
            $display("FAIL cdb_invalid_ignored: q2_ready=%b count=%0d, want 0 3", q2_ready, count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_one(1'b1, 5'd8);
        alloc_one(1'b1, 5'd9);
        alloc_one(1'b1, 5'd10);
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h0000_0077;
        tick();
        cdb_valid = 1'b0;
        flush = 1'b1;
        alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd11;
        #1;
        checks++;
        if (commit_we !== 1'b0 || commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_suppress: we=%b valid=%b, want 0 0", commit_we, commit_valid);
        end
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || alloc_tag !== 3'd0) begin
            failures++;
            $display("FAIL flush_state: count=%0d empty=%b tag=%0d, want 0 1 0", count, empty, alloc_tag);
        end
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'h0000_0099;
        tick();
        cdb_valid = 1'b0;
        q1_tag = 3'd1;
        #1;
        checks++;
        if (q1_ready !== 1'b0 || commit_valid !== 1'b0 || count !== 4'd0) begin
            failures++;
            $display("FAIL flush_stale_cdb: q1_ready=%b valid=%b count=%0d, want 0 0 0",
                     q1_ready, commit_valid, count);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        alloc_one(1'b1, 5'd12);
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h0000_ABCD;
        tick();
        cdb_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (commit_we !== 1'b0 || commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_suppress: we=%b valid=%b, want 0 0", commit_we, commit_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_state: count=%0d empty=%b valid=%b, want 0 1 0", count, empty, commit_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_fill_and_full_commit();
        test_single_commit();
        test_out_of_order();
        test_lookup();
        test_flush();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
